// File: rtl/lcd_row_formatter_pkg.sv
// lcd_pkg: shared constants, state enum and magnitude helper for lcd_row_formatter
package lcd_pkg;
  localparam int T_W = 12;
  localparam int MAG_MAX = 999;
  localparam int DD_ITERS = 10;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] MINUS = 8'h2D;
  localparam logic [7:0] DOT = 8'h2E;
  localparam logic [7:0] ZERO = 8'h30;
  localparam logic [39:0] TEMP_STR = "TEMP:";
  localparam logic [31:0] SET_STR = "SET:";
  localparam logic [47:0] OK_STR = "OK    ";
  localparam logic [47:0] ALARM_STR = "ALARM!";
  typedef enum logic [2:0] {IDLE, LATCH, CONV_T, CONV_S, BUILD} state_t;
  function automatic logic [9:0] sat_mag(input logic [T_W-1:0] x);
    logic [T_W-1:0] m;
    m = x[T_W-1] ? T_W'(-x) : x;
    return (m > T_W'(MAG_MAX)) ? 10'(MAG_MAX) : m[9:0];
  endfunction
endpackage

// File: rtl/lcd_row_formatter_if.sv
// lcd_row_formatter_if: request/result bundle between the sensor side and the row formatter
interface lcd_row_formatter_if;
  import lcd_pkg::*;
  logic start;
  logic [T_W-1:0] temp_x10;
  logic [T_W-1:0] setp_x10;
  logic alarm;
  logic busy;
  logic valid;
  logic [127:0] row1;
  logic [127:0] row2;
  modport master(output start, temp_x10, setp_x10, alarm, input busy, valid, row1, row2);
  modport slave(input start, temp_x10, setp_x10, alarm, output busy, valid, row1, row2);
endinterface

// File: rtl/lcd_bin2bcd_seq.sv
// lcd_bin2bcd_seq: iterative double-dabble, 10-bit binary to 3 BCD digits; load performs the first iteration
module lcd_bin2bcd_seq (
  input  logic        clk_1MHz,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic [9:0]  bin,
  output logic [11:0] bcd
);
  logic [21:0] sr_q, sr_d, src, adj;
  always_comb begin
    src = load ? {12'd0, bin} : sr_q;
    adj = src;
    for (int i = 0; i < 3; i++)
      adj[10+4*i +: 4] = (src[10+4*i +: 4] >= 4'd5) ? src[10+4*i +: 4] + 4'd3 : src[10+4*i +: 4];
    sr_d = (load | step) ? (adj << 1) : sr_q;
  end
  always_ff @(posedge clk_1MHz or negedge rst_n)
    if (!rst_n) sr_q <= '0;
    else sr_q <= sr_d;
  assign bcd = sr_q[21:10];
endmodule

// File: rtl/lcd_row_formatter.sv
// lcd_row_formatter: captures temp/setpoint/alarm, converts to BCD, builds two 16-char ASCII rows.
// Define LCD_ROW_ZSUP_EN to blank a zero tens digit.
module lcd_row_formatter
  import lcd_pkg::*;
(
  input logic clk_1MHz,
  input logic rst_n,
  lcd_row_formatter_if.slave bus
);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [T_W-1:0] temp_q, temp_d, setp_q, setp_d;
  logic alarm_q, alarm_d, valid_q, valid_d;
  logic [11:0] tbcd_q, tbcd_d, bcd;
  logic [127:0] row1_q, row1_d, row2_q, row2_d;
  logic load, step;
  logic [9:0] bin;
  function automatic logic [39:0] num_field(input logic neg, input logic [11:0] b);
    logic [7:0] d2;
`ifdef LCD_ROW_ZSUP_EN
    d2 = (b[11:8] == 4'd0) ? SPACE : (ZERO | {4'd0, b[11:8]});
`else
    d2 = ZERO | {4'd0, b[11:8]};
`endif
    return {neg ? MINUS : SPACE, d2, ZERO | {4'd0, b[7:4]}, DOT, ZERO | {4'd0, b[3:0]}};
  endfunction
  lcd_bin2bcd_seq u_bcd (.clk_1MHz(clk_1MHz), .rst_n(rst_n), .load(load), .step(step), .bin(bin), .bcd(bcd));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    temp_d = temp_q;
    setp_d = setp_q;
    alarm_d = alarm_q;
    tbcd_d = tbcd_q;
    row1_d = row1_q;
    row2_d = row2_q;
    valid_d = 1'b0;
    load = 1'b0;
    step = 1'b0;
    bin = sat_mag(temp_q);
    case (state_q)
      IDLE: if (bus.start) begin
        temp_d = bus.temp_x10;
        setp_d = bus.setp_x10;
        alarm_d = bus.alarm;
        state_d = LATCH;
      end
      LATCH: begin
        load = 1'b1;
        cnt_d = '0;
        state_d = CONV_T;
      end
      // the last temp slot banks the finished digits and loads the setpoint in the same edge
      CONV_T: if (cnt_q == 4'(DD_ITERS - 1)) begin
        tbcd_d = bcd;
        bin = sat_mag(setp_q);
        load = 1'b1;
        cnt_d = '0;
        state_d = CONV_S;
      end else begin
        step = 1'b1;
        cnt_d = cnt_q + 4'd1;
      end
      CONV_S: if (cnt_q == 4'(DD_ITERS - 1)) state_d = BUILD;
      else begin
        step = 1'b1;
        cnt_d = cnt_q + 4'd1;
      end
      default: begin
        row1_d = {TEMP_STR, num_field(temp_q[T_W-1], tbcd_q), SPACE, 8'h43, {4{SPACE}}};
        row2_d = {SET_STR, num_field(setp_q[T_W-1], bcd), SPACE, alarm_q ? ALARM_STR : OK_STR};
        valid_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk_1MHz or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      temp_q <= '0;
      setp_q <= '0;
      alarm_q <= 1'b0;
      tbcd_q <= '0;
      row1_q <= {16{SPACE}};
      row2_q <= {16{SPACE}};
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      temp_q <= temp_d;
      setp_q <= setp_d;
      alarm_q <= alarm_d;
      tbcd_q <= tbcd_d;
      row1_q <= row1_d;
      row2_q <= row2_d;
      valid_q <= valid_d;
    end
  assign bus.busy = (state_q == CONV_T) || (state_q == CONV_S) || (state_q == BUILD);
  assign bus.valid = valid_q;
  assign bus.row1 = row1_q;
  assign bus.row2 = row2_q;
endmodule

// File: tb/tb_lcd_row_formatter.sv
// tb_lcd_row_formatter: randomized scoreboard bench with a decimal-arithmetic row model
module tb_lcd_row_formatter;
  import lcd_pkg::*;
  typedef struct {
    logic [127:0] r1;
    logic [127:0] r2;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int run = 0;
  exp_t q[$];
  logic [127:0] held1, held2;
  localparam logic [127:0] BLANK = "                ";
  lcd_row_formatter_if bus();
  lcd_row_formatter dut (.clk_1MHz(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  function automatic logic [39:0] fld(input int v);
    int m;
    logic [7:0] sg, d2, d1, d0;
    m = (v < 0) ? -v : v;
    if (m > 999) m = 999;
    sg = (v < 0) ? "-" : " ";
    d2 = 8'(48 + m / 100);
    d1 = 8'(48 + (m / 10) % 10);
    d0 = 8'(48 + m % 10);
`ifdef LCD_ROW_ZSUP_EN
    if (m < 100) d2 = " ";
`endif
    return {sg, d2, d1, ".", d0};
  endfunction
  task automatic run_txn(input int t, input int s, input bit a);
    exp_t e;
    logic [47:0] st;
    st = a ? "ALARM!" : "OK    ";
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.temp_x10 = 12'(t);
    bus.setp_x10 = 12'(s);
    bus.alarm = a;
    e.r1 = {"TEMP:", fld(t), " C    "};
    e.r2 = {"SET:", fld(s), " ", st};
    e.cyc = cyc + 23;
    q.push_back(e);
    for (int k = 1; k <= 23; k++) begin
      @(posedge clk); #1;
      bus.start = (k == 5 || k == 15);
      bus.temp_x10 = 12'($urandom);
      bus.setp_x10 = 12'($urandom);
      bus.alarm = 1'($urandom);
    end
    bus.start = 1'b0;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held1 = BLANK;
      held2 = BLANK;
      run = 0;
    end else begin
      if (bus.valid) begin
        if (q.size() == 0) check("unexpected_valid", 128'(bus.valid), 128'(0));
        else begin
          e = q.pop_front();
          check("row1", bus.row1, e.r1);
          check("row2", bus.row2, e.r2);
          check("latency", 128'(cyc), 128'(e.cyc));
          check("busy_in_valid", 128'(bus.busy), 128'(0));
          check("busy_run", 128'(run), 128'(21));
          held1 = e.r1;
          held2 = e.r2;
        end
      end else begin
        check("row1_hold", bus.row1, held1);
        check("row2_hold", bus.row2, held2);
      end
      run = bus.busy ? run + 1 : 0;
    end
  end
  initial begin
    int t, s;
    bus.start = 1'b0;
    bus.temp_x10 = '0;
    bus.setp_x10 = '0;
    bus.alarm = 1'b0;
    #12;
    check("rst_row1", bus.row1, BLANK);
    check("rst_row2", bus.row2, BLANK);
    check("rst_busy", 128'(bus.busy), 128'(0));
    check("rst_valid", 128'(bus.valid), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_txn(-125, -180, 1'b0);
    run_txn(0, 45, 1'b0);
    run_txn(1500, -2048, 1'b1);
    run_txn(999, -999, 1'b0);
    run_txn(-1000, 1000, 1'b1);
    run_txn(-5, 99, 1'b0);
    run_txn(2047, 100, 1'b1);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.temp_x10 = 12'(-333);
    bus.setp_x10 = 12'(444);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_row1", bus.row1, BLANK);
    check("midrst_row2", bus.row2, BLANK);
    check("midrst_busy", 128'(bus.busy), 128'(0));
    check("midrst_valid", 128'(bus.valid), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    run_txn(-125, -180, 1'b0);
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) begin
        t = int'($urandom_range(0, 4095)) - 2048;
        s = int'($urandom_range(0, 4095)) - 2048;
      end else begin
        t = int'($urandom_range(0, 2200)) - 1100;
        s = int'($urandom_range(0, 198)) - 99;
      end
      run_txn(t, s, 1'($urandom));
    end
    for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
    check("drain", 128'(q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lcd_row_formatter.md
Name: lcd_row_formatter

Overview:
Upstream stage of lcd_write_frame in the cold-storage display path. On a start pulse it captures a signed temperature, a signed setpoint (both in tenths of °C) and an alarm flag. It converts each to BCD with an iterative shift-add-3 converter, then builds two 16-character ASCII rows in the 128-bit row1/row2 format the frame writer consumes. Conversion is sequential with fixed latency; the rows are registered and held stable between updates.

Parameters:
T_W, 12, width of the signed two's-complement temp/setpoint inputs, in units of 0.1 °C.
MAG_MAX, 999, saturation limit for magnitude in tenths, giving a display range of ±99.9.

Ports:
clk_1MHz  input  1  system clock, 1 MHz
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to format; sampled only in IDLE
temp_x10  input  T_W  signed temperature in tenths of °C
setp_x10  input  T_W  signed setpoint in tenths of °C
alarm  input  1  alarm status, captured together with start
busy  output  1  high from the cycle after start is accepted until valid
valid  output  1  one-cycle pulse when row1/row2 are updated
row1  output  128  line 1 ASCII; character 1 in [127:120], character 16 in [7:0]
row2  output  128  line 2 ASCII; same byte ordering as row1

Behaviour:
- Clock and reset: one clock (clk_1MHz); reset is asynchronous and active-low (rst_n).
- Reset values: row1 = row2 = sixteen 0x20 characters; valid = 0; busy = 0; FSM in IDLE.
- FSM states: IDLE, LATCH, CONV_T, CONV_S, BUILD.
  - IDLE: when start = 1, capture temp_x10, setp_x10 and alarm, then go to LATCH.
  - LATCH: compute sign and magnitude of each value. Magnitude = |x|, saturated to MAG_MAX (10 bits). Go to CONV_T.
  - CONV_T: 10 double-dabble iterations, one per clock, yielding hundreds/tens/units BCD digits. Then go to CONV_S.
  - CONV_S: same 10 iterations for the setpoint. Then go to BUILD.
  - BUILD: register row1/row2, pulse valid for 1 cycle, return to IDLE.
- Latency: valid is high in the cycle after the 22nd rising edge following the edge that samples start. busy is high for 21 consecutive cycles before valid; busy = 0 in the valid cycle.
- Start handling: start is ignored outside IDLE. No queuing; the captured inputs cannot change during a conversion.
- Row1 layout, columns 1-16: "TEMP:", S, D2, D1, '.', D0, ' ', 'C', then 4 spaces.
  - S = '-' (0x2D) if the captured value is negative, otherwise ' '.
  - D2/D1/D0 are ASCII 0x30 + BCD digit (tens, units, tenths).
- Row2 layout, columns 1-16: "SET:", S, D2, D1, '.', D0, ' ', then a 6-character status field.
  - Status = "ALARM!" if the captured alarm = 1, else "OK    ".
- Saturation: if |x| > MAG_MAX, the magnitude becomes 999 ("99.9") and the sign is preserved. The most-negative input (−2048) must be handled without overflow.
- Row hold: rows change only in BUILD and are held otherwise. valid never asserts twice without an intervening start.
- Reset mid-operation: aborts immediately. Rows return to spaces, no valid pulse is issued, FSM is in IDLE.

Optional Feature:
Macro LCD_ROW_ZSUP_EN enables leading-zero suppression.
- Defined: a zero tens digit D2 is rendered as ' ' (0x20); the sign stays in its own column.
- Undefined: D2 is always shown as a digit.
Latency and all other fields are identical in both builds.

Decomposition:
- Shared package lcd_pkg:
  - ASCII constants: SPACE, MINUS, DOT, ZERO.
  - The "TEMP:", "SET:", "OK    " and "ALARM!" field constants.
  - FSM state enum.
  - Constant DD_ITERS = 10.
- One sub-module, lcd_bin2bcd_seq: an iterative 10-bit to 3-digit BCD converter with load/step inputs and a 12-bit BCD output. It is instantiated once and reused for both values.

Test Plan:
- temp_x10 = −125, setp_x10 = −180, alarm = 0, start → after 22 edges, row1 = "TEMP:-12.5 C    " and row2 = "SET:-18.0 OK    "; valid is high for exactly 1 cycle.
- temp_x10 = 0, setp_x10 = 45 → without the macro, row1 = "TEMP: 00.0 C    "; with LCD_ROW_ZSUP_EN, row1 = "TEMP:  0.0 C    " and row2 = "SET:  4.5 OK    ".
- temp_x10 = 1500, setp_x10 = −2048, alarm = 1 → row1 = "TEMP: 99.9 C    " and row2 = "SET:-99.9 ALARM!".
- Start re-pulsed at cycles 5 and 15 with new data → ignored; rows reflect the first captured values; busy stays high for 21 cycles.
- rst_n asserted at cycle 10 of a conversion → rows = all 0x20, valid never pulses, busy = 0. A fresh start then completes normally in 22 edges.
- Inputs changed every cycle during busy → output rows match the values captured at the start edge.
